// File: rtl/biquad_coeff_sequencer.sv
// Wishbone-master sequencer: streams stored notch coefficient sets into the
// trigger-chain biquads, then strobes each update and an optional reset pulse.
module biquad_coeff_sequencer #(
   parameter int         NBQ        = 2,
   parameter logic [7:0] BQ_STRIDE  = 8'h80,
   parameter int         NSETS      = 8,
   parameter int         RST_CYCLES = 32,
   parameter int         TIMEOUT    = 255
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic                         cfg_we_i,
   input  logic [$clog2(NSETS*25)-1:0]  cfg_addr_i,
   input  logic [31:0]                  cfg_dat_i,
   input  logic                         start_i,
   input  logic [$clog2(NSETS)-1:0]     set_i,
   input  logic [NBQ-1:0]               bq_mask_i,
   input  logic                         reset_after_i,
   output logic                         wm_cyc_o,
   output logic                         wm_stb_o,
   output logic                         wm_we_o,
   output logic [3:0]                   wm_sel_o,
   output logic [7:0]                   wm_adr_o,
   output logic [31:0]                  wm_dat_o,
   input  logic                         wm_ack_i,
   input  logic                         wm_err_i,
   output logic                         bq_reset_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         err_o
);

   localparam int AW     = $clog2(NSETS*25);
   localparam int SW     = $clog2(NSETS);
   localparam int BW     = $clog2(NBQ+1);
   localparam int TW     = $clog2(TIMEOUT+1);
   localparam int RW     = $clog2(RST_CYCLES+1);
   localparam int NWORDS = NSETS*25;

   typedef enum logic [2:0] {IDLE, FETCH, WRITE, UPD, RSTP, DONE} state_t;

   state_t          state, state_n;
   logic [4:0]      idx, idx_n;
   logic [BW-1:0]   bq, bq_n;
   logic [SW-1:0]   set_q, set_n;
   logic [NBQ-1:0]  mask, mask_n;
   logic            rst_after, rst_after_n;
   logic            cyc, cyc_n;
   logic [7:0]      adr, adr_n;
   logic [31:0]     dat, dat_n;
   logic            pulse, pulse_n;
   logic            busy, busy_n;
   logic            done, done_n;
   logic            err, err_n;
   logic [TW-1:0]   tcnt, tcnt_n;
   logic [RW-1:0]   rcnt, rcnt_n;

   logic [31:0]     mem [NWORDS];
   logic [AW-1:0]   rd_addr;
   logic [BW-1:0]   first_bq, next_bq;
   logic            first_ok, next_ok;
   logic            abort;

   function automatic logic [7:0] reg_off(input logic [4:0] i);
      if (i <= 5'd1)       return 8'h04;
      else if (i <= 5'd5)  return 8'h08;
      else if (i <= 5'd7)  return 8'h0C;
      else if (i <= 5'd14) return 8'h10;
      else if (i <= 5'd22) return 8'h14;
      else if (i == 5'd23) return 8'h18;
      else                 return 8'h1C;
   endfunction

   function automatic logic [7:0] bq_addr(input logic [BW-1:0] k, input logic [7:0] off);
      return 8'(32'(k) * 32'(BQ_STRIDE) + 32'(off));
   endfunction

   // RAM contents are deliberately not reset.
   always_ff @(posedge wb_clk_i) begin
      if (cfg_we_i && !busy && (32'(cfg_addr_i) < 32'(NWORDS)))
         mem[cfg_addr_i] <= cfg_dat_i;
   end

   always_comb begin
      int unsigned s;
      s       = (32'(set_q) + 32'(bq)) % 32'(NSETS);
      rd_addr = AW'(s * 32'd25 + 32'(idx));
   end

   // Lowest enabled biquad overall (for start) and after the current one.
   always_comb begin
      logic [NBQ-1:0] msh_i, msh_q;
      first_ok = 1'b0;
      first_bq = '0;
      next_ok  = 1'b0;
      next_bq  = '0;
      for (int unsigned k = NBQ; k > 0; k--) begin
         msh_i = bq_mask_i >> (k - 1);
         msh_q = mask >> (k - 1);
         if (msh_i[0]) begin
            first_ok = 1'b1;
            first_bq = BW'(k - 1);
         end
         if (msh_q[0] && ((k - 1) > 32'(bq))) begin
            next_ok = 1'b1;
            next_bq = BW'(k - 1);
         end
      end
   end

   assign abort = cyc && (wm_err_i || (!wm_ack_i && (tcnt == TW'(TIMEOUT - 1))));

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      bq_n        = bq;
      set_n       = set_q;
      mask_n      = mask;
      rst_after_n = rst_after;
      cyc_n       = cyc;
      adr_n       = adr;
      dat_n       = dat;
      err_n       = err;
      rcnt_n      = rcnt;
      tcnt_n      = cyc ? tcnt + 1'b1 : tcnt;

      case (state)
         IDLE: begin
            if (start_i) begin
               set_n       = set_i;
               mask_n      = bq_mask_i;
               rst_after_n = reset_after_i;
               err_n       = 1'b0;
               idx_n       = '0;
               rcnt_n      = '0;
               if (first_ok) begin
                  bq_n    = first_bq;
                  state_n = FETCH;
               end else if (reset_after_i) begin
                  state_n = RSTP;
               end else begin
                  state_n = DONE;
               end
            end
         end
         FETCH: begin
            dat_n   = mem[rd_addr];
            adr_n   = bq_addr(bq, reg_off(idx));
            cyc_n   = 1'b1;
            tcnt_n  = '0;
            state_n = WRITE;
         end
         WRITE: begin
            if (abort) begin
               cyc_n   = 1'b0;
               err_n   = 1'b1;
               state_n = DONE;
            end else if (wm_ack_i) begin
               cyc_n = 1'b0;
               if (idx == 5'd24) begin
                  state_n = UPD;
               end else begin
                  idx_n   = idx + 5'd1;
                  state_n = FETCH;
               end
            end
         end
         // First UPD cycle keeps cyc low, matching the gap FETCH gives data words.
         UPD: begin
            if (!cyc) begin
               cyc_n  = 1'b1;
               adr_n  = bq_addr(bq, 8'h00);
               dat_n  = 32'd1;
               tcnt_n = '0;
            end else if (abort) begin
               cyc_n   = 1'b0;
               err_n   = 1'b1;
               state_n = DONE;
            end else if (wm_ack_i) begin
               cyc_n = 1'b0;
               idx_n = '0;
               if (next_ok) begin
                  bq_n    = next_bq;
                  state_n = FETCH;
               end else if (rst_after) begin
                  rcnt_n  = '0;
                  state_n = RSTP;
               end else begin
                  state_n = DONE;
               end
            end
         end
         RSTP: begin
            rcnt_n = rcnt + 1'b1;
            if (rcnt == RW'(RST_CYCLES - 1))
               state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      pulse_n = (state_n == RSTP);
      busy_n  = (state_n != IDLE);
      done_n  = (state_n == DONE);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         idx       <= '0;
         bq        <= '0;
         set_q     <= '0;
         mask      <= '0;
         rst_after <= 1'b0;
         cyc       <= 1'b0;
         adr       <= '0;
         dat       <= '0;
         pulse     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         tcnt      <= '0;
         rcnt      <= '0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         bq        <= bq_n;
         set_q     <= set_n;
         mask      <= mask_n;
         rst_after <= rst_after_n;
         cyc       <= cyc_n;
         adr       <= adr_n;
         dat       <= dat_n;
         pulse     <= pulse_n;
         busy      <= busy_n;
         done      <= done_n;
         err       <= err_n;
         tcnt      <= tcnt_n;
         rcnt      <= rcnt_n;
      end
   end

   assign wm_cyc_o   = cyc;
   assign wm_stb_o   = cyc;
   assign wm_we_o    = cyc;
   assign wm_sel_o   = {4{cyc}};
   assign wm_adr_o   = adr;
   assign wm_dat_o   = dat;
   assign bq_reset_o = pulse;
   assign busy_o     = busy;
   assign done_o     = done;
   assign err_o      = err;

endmodule

// File: tb/tb_biquad_coeff_sequencer.sv
// Bench for biquad_coeff_sequencer: table of start commands with a Wishbone
// slave model feeding a write scoreboard, plus reset and busy-lockout sequences.
module tb_biquad_coeff_sequencer;

   localparam int NBQ        = 2;
   localparam int NSETS      = 8;
   localparam int RST_CYCLES = 32;
   localparam int TIMEOUT    = 255;
   localparam int NW         = NSETS * 25;

   localparam logic [7:0] OFF_TAB [25] = '{
      8'h04, 8'h04,
      8'h08, 8'h08, 8'h08, 8'h08,
      8'h0C, 8'h0C,
      8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10,
      8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14,
      8'h18,
      8'h1C};

   logic        clk = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        cfg_we_i = 1'b0;
   logic [7:0]  cfg_addr_i = '0;
   logic [31:0] cfg_dat_i = '0;
   logic        start_i = 1'b0;
   logic [2:0]  set_i = '0;
   logic [1:0]  bq_mask_i = '0;
   logic        reset_after_i = 1'b0;
   logic        wm_cyc_o, wm_stb_o, wm_we_o;
   logic [3:0]  wm_sel_o;
   logic [7:0]  wm_adr_o;
   logic [31:0] wm_dat_o;
   logic        wm_ack_i = 1'b0;
   logic        wm_err_i = 1'b0;
   logic        bq_reset_o, busy_o, done_o, err_o;

   always #5 clk = ~clk;

   biquad_coeff_sequencer #(
      .NBQ(NBQ), .BQ_STRIDE(8'h80), .NSETS(NSETS),
      .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
      .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_dat_i(cfg_dat_i),
      .start_i(start_i), .set_i(set_i), .bq_mask_i(bq_mask_i),
      .reset_after_i(reset_after_i),
      .wm_cyc_o(wm_cyc_o), .wm_stb_o(wm_stb_o), .wm_we_o(wm_we_o),
      .wm_sel_o(wm_sel_o), .wm_adr_o(wm_adr_o), .wm_dat_o(wm_dat_o),
      .wm_ack_i(wm_ack_i), .wm_err_i(wm_err_i),
      .bq_reset_o(bq_reset_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   typedef struct {
      logic [7:0]  adr;
      logic [31:0] dat;
   } xfer_t;

   typedef struct {
      int set, mask, ra, delay, err_at, noack;
      int lim, exp_err, exp_rst, exp_lat, exp_cmax;
   } vec_t;

   int          n_checks = 0;
   int          n_fail = 0;
   xfer_t       exp_q[$];
   logic [31:0] ram_m [NW];
   vec_t        vecs [10];

   int ack_delay = 0, err_at = 0, no_ack = 0;
   int cyc_run = 0, bus_n = 0, xfers = 0, rst_cnt = 0, done_cnt = 0, cyc_max = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Slave: acks after ack_delay extra clocks, or errors on bus cycle err_at.
   always @(negedge clk) begin
      xfer_t e;
      wm_ack_i = 1'b0;
      wm_err_i = 1'b0;
      if (bq_reset_o) rst_cnt++;
      if (done_o) done_cnt++;
      if (wm_cyc_o) begin
         cyc_run++;
         if (cyc_run == 1) bus_n++;
         if (cyc_run > cyc_max) cyc_max = cyc_run;
         if (err_at != 0 && bus_n == err_at) begin
            wm_err_i = 1'b1;
         end else if (no_ack == 0 && cyc_run > ack_delay) begin
            wm_ack_i = 1'b1;
            xfers++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got adr=%h dat=%h, want none", wm_adr_o, wm_dat_o);
            end else begin
               e = exp_q.pop_front();
               check("write", {wm_we_o, wm_stb_o, wm_sel_o, wm_adr_o, wm_dat_o},
                     {1'b1, 1'b1, 4'hF, e.adr, e.dat});
            end
         end
      end else begin
         cyc_run = 0;
      end
   end

   task automatic push_expected(input int set, input int mask, input int lim);
      int n = 0;
      for (int k = 0; k < NBQ; k++) begin
         if (((mask >> k) & 1) != 0) begin
            int s = (set + k) % NSETS;
            for (int i = 0; i <= 25; i++) begin
               xfer_t x;
               if (i < 25) begin
                  x.adr = 8'(k * 128 + int'(OFF_TAB[i]));
                  x.dat = ram_m[s * 25 + i];
               end else begin
                  x.adr = 8'(k * 128);
                  x.dat = 32'd1;
               end
               if (n < lim) exp_q.push_back(x);
               n++;
            end
         end
      end
   endtask

   task automatic arm(input vec_t v);
      exp_q.delete();
      push_expected(v.set, v.mask, v.lim);
      ack_delay = v.delay; err_at = v.err_at; no_ack = v.noack;
      bus_n = 0; cyc_max = 0; rst_cnt = 0; done_cnt = 0; xfers = 0;
      @(posedge clk); #1;
      start_i = 1'b1;
      set_i = 3'(v.set);
      bq_mask_i = 2'(v.mask);
      reset_after_i = (v.ra != 0);
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input bit inject);
      int lat = 0;
      bit seen = 0;
      arm(v);
      check("busy_after_start", busy_o, 1);
      check("err_cleared_at_start", err_o, 0);
      for (int c = 1; c <= 3000 && !seen; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         if (inject && c == 10) begin
            cfg_we_i = 1'b1; cfg_addr_i = 8'd5; cfg_dat_i = 32'hDEAD_BEEF;
            start_i = 1'b1; set_i = 3'd3; bq_mask_i = 2'b11; reset_after_i = 1'b1;
         end else if (inject && c == 11) begin
            cfg_we_i = 1'b0; start_i = 1'b0;
         end
         if (done_o) begin seen = 1; lat = c; end
      end
      check("done_latency", lat, v.exp_lat);
      check("busy_at_done", busy_o, 1);
      check("err_at_done", err_o, v.exp_err);
      @(posedge clk); #1;
      check("busy_after_done", busy_o, 0);
      check("done_one_cycle", done_o, 0);
      repeat (5) @(posedge clk);
      #1;
      check("done_count", done_cnt, 1);
      check("reset_pulse_cycles", rst_cnt, v.exp_rst);
      check("cyc_max_run", cyc_max, v.exp_cmax);
      check("pending_writes", exp_q.size(), 0);
      check("err_sticky", err_o, v.exp_err);
   endtask

   initial begin
      vec_t v;
      //          set mask ra dly err noack lim err rst  lat  cmax
      vecs[0] = '{0,  3,   0, 0,  0,  0,    52, 0,  0,   105, 1};
      vecs[1] = '{7,  2,   0, 0,  0,  0,    26, 0,  0,   53,  1};
      vecs[2] = '{3,  0,   1, 0,  0,  0,    0,  0,  32,  33,  0};
      vecs[3] = '{5,  1,   1, 2,  0,  0,    26, 0,  32,  137, 3};
      vecs[4] = '{2,  3,   1, 0,  0,  0,    52, 0,  32,  137, 1};
      vecs[5] = '{0,  0,   0, 0,  0,  0,    0,  0,  0,   1,   0};
      vecs[6] = '{1,  1,   1, 0,  0,  1,    0,  1,  0,   257, 255};
      vecs[7] = '{4,  3,   0, 1,  0,  0,    52, 0,  0,   157, 2};
      vecs[8] = '{6,  3,   1, 0,  3,  0,    2,  1,  0,   7,   1};
      vecs[9] = '{7,  1,   0, 0,  0,  0,    26, 0,  0,   53,  1};

      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {wm_cyc_o, wm_stb_o, wm_we_o, wm_sel_o, wm_adr_o, wm_dat_o,
                            bq_reset_o, busy_o, done_o, err_o}, 64'd0);
      wb_rst_i = 1'b0;

      for (int a = 0; a < NW; a++) begin
         logic [31:0] d;
         if (a < 25)      d = 32'(a);
         else if (a < 50) d = 32'(100 + a - 25);
         else             d = $urandom;
         @(posedge clk); #1;
         cfg_we_i = 1'b1; cfg_addr_i = 8'(a); cfg_dat_i = d;
         ram_m[a] = d;
      end
      @(posedge clk); #1;
      cfg_we_i = 1'b0;

      for (int t = 0; t < 10; t++) run_vec(vecs[t], 1'b0);

      // Synchronous reset during the 10th write of a two-biquad load.
      v = '{0, 3, 0, 3, 0, 0, 9, 0, 0, 0, 0};
      arm(v);
      for (int c = 0; c < 500 && bus_n < 10; c++) begin
         @(posedge clk); #1;
      end
      check("bus_cycle_at_reset", bus_n, 10);
      wb_rst_i = 1'b1;
      @(posedge clk); #1;
      check("outputs_after_reset", {wm_cyc_o, wm_stb_o, wm_we_o, wm_sel_o, wm_adr_o, wm_dat_o,
                                    bq_reset_o, busy_o, done_o, err_o}, 64'd0);
      wb_rst_i = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("writes_before_reset", xfers, 9);
      check("pending_after_reset", exp_q.size(), 0);
      check("no_done_after_reset", done_cnt, 0);
      run_vec(vecs[0], 1'b0);

      // Busy lockout: RAM write and start pulsed mid-sequence must be ignored.
      v = '{0, 1, 0, 0, 0, 0, 26, 0, 0, 53, 1};
      run_vec(v, 1'b1);
      run_vec(v, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
